// File: rtl/cam_alloc_if.sv
// Insert request/response handshake between a requester and cam_alloc.
interface cam_alloc_if #(
    parameter int KEY_W  = 8,
    parameter int ADDR_W = 5
) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic [KEY_W-1:0]  req_key_i;
    logic              rsp_valid_o;
    logic              rsp_hit_o;
    logic              rsp_full_o;
    logic [ADDR_W-1:0] rsp_addr_o;

    modport slave (
        input  req_valid_i, req_key_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_full_o, rsp_addr_o
    );

    modport master (
        output req_valid_i, req_key_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_full_o, rsp_addr_o
    );
endinterface

// File: rtl/cam_alloc.sv
// Insert/free controller in front of a CAM: duplicate check, slot allocation, occupancy bitmap.
// Optional macro CAM_ALLOC_STATS_EN adds saturating hit/insert/full response counters.
module cam_alloc #(
    parameter int CNT_N = 32,
    parameter int KEY_W = 8,
    localparam int ADDR_W = $clog2(CNT_N)
) (
    input  logic              clk,
    input  logic              reset,
    cam_alloc_if.slave        req,
    input  logic              free_i,
    input  logic [ADDR_W-1:0] free_addr_i,
    output logic              cam_rd_o,
    output logic [KEY_W-1:0]  cam_rd_key_o,
    input  logic              cam_match_i,
    input  logic [ADDR_W-1:0] cam_addr_i,
    input  logic              cam_error_i,
    output logic              cam_alloc_o,
    output logic [CNT_N-1:0]  cam_alloc_pos_o,
    output logic [KEY_W-1:0]  cam_alloc_key_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
`ifdef CAM_ALLOC_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [31:0]       stat_hit_o,
    output logic [31:0]       stat_ins_o,
    output logic [31:0]       stat_full_o
`endif
);
    typedef enum logic [1:0] {IDLE, LOOKUP, ALLOC, RESP} state_t;

    state_t            state;
    logic [KEY_W-1:0]  key_q;
    logic [CNT_N-1:0]  used_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] target_q;
    logic              err_q;
    logic              ready_q;
    logic              rsp_valid_q, rsp_hit_q, rsp_full_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic              cam_rd_q, cam_alloc_q;
    logic [CNT_N-1:0]  cam_pos_q;

    logic              free_in_range, free_ok, cam_in_range, live_hit, full;
    logic              alloc_now;
    logic [CNT_N-1:0]  free_mask, alloc_mask;
    logic [ADDR_W-1:0] low_idx;

    assign full          = (count_q == (ADDR_W+1)'(CNT_N));
    assign free_in_range = ((ADDR_W+1)'(free_addr_i) < (ADDR_W+1)'(CNT_N));
    assign free_ok       = free_i & free_in_range & used_q[free_addr_i];
    assign cam_in_range  = ((ADDR_W+1)'(cam_addr_i) < (ADDR_W+1)'(CNT_N));
    // A CAM match only counts if the bitmap still owns the entry and it is not being freed now.
    assign live_hit      = cam_match_i & cam_in_range & used_q[cam_addr_i]
                         & ~(free_i & (free_addr_i == cam_addr_i));
    assign alloc_now     = (state == ALLOC);
    assign free_mask     = free_ok   ? (CNT_N'(1) << free_addr_i) : '0;
    assign alloc_mask    = alloc_now ? (CNT_N'(1) << target_q)    : '0;

    always_comb begin
        low_idx = '0;
        for (int unsigned i = CNT_N; i > 0; i--) begin
            if (!used_q[i-1]) low_idx = ADDR_W'(i-1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            key_q       <= '0;
            used_q      <= '0;
            count_q     <= '0;
            target_q    <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_full_q  <= 1'b0;
            rsp_addr_q  <= '0;
            cam_rd_q    <= 1'b0;
            cam_alloc_q <= 1'b0;
            cam_pos_q   <= '0;
        end else begin
            used_q      <= (used_q | alloc_mask) & ~free_mask;
            count_q     <= count_q + (ADDR_W+1)'(alloc_now) - (ADDR_W+1)'(free_ok);
            if (free_i && !free_ok) err_q <= 1'b1;

            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_full_q  <= 1'b0;
            rsp_addr_q  <= '0;
            cam_rd_q    <= 1'b0;
            cam_alloc_q <= 1'b0;
            cam_pos_q   <= '0;

            case (state)
                IDLE: begin
                    if (req.req_valid_i && ready_q) begin
                        key_q    <= req.req_key_i;
                        state    <= LOOKUP;
                        ready_q  <= 1'b0;
                        cam_rd_q <= 1'b1;
                    end else begin
                        ready_q  <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (cam_error_i) err_q <= 1'b1;
                    if (live_hit) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b1;
                        rsp_addr_q  <= cam_addr_i;
                    end else if (cam_match_i) begin
                        // Reuse the stale slot so the CAM never holds the key twice.
                        state       <= ALLOC;
                        target_q    <= cam_addr_i;
                        cam_alloc_q <= 1'b1;
                        cam_pos_q   <= CNT_N'(1) << cam_addr_i;
                    end else if (!full) begin
                        state       <= ALLOC;
                        target_q    <= low_idx;
                        cam_alloc_q <= 1'b1;
                        cam_pos_q   <= CNT_N'(1) << low_idx;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_full_q  <= 1'b1;
                    end
                end
                ALLOC: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= target_q;
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req.req_ready_o = ready_q;
    assign req.rsp_valid_o = rsp_valid_q;
    assign req.rsp_hit_o   = rsp_hit_q;
    assign req.rsp_full_o  = rsp_full_q;
    assign req.rsp_addr_o  = rsp_addr_q;
    assign cam_rd_o        = cam_rd_q;
    assign cam_rd_key_o    = key_q;
    assign cam_alloc_o     = cam_alloc_q;
    assign cam_alloc_pos_o = cam_pos_q;
    assign cam_alloc_key_o = key_q;
    assign count_o         = count_q;
    assign full_o          = full;
    assign err_o           = err_q;

`ifdef CAM_ALLOC_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hit_o  <= '0;
            stat_ins_o  <= '0;
            stat_full_o <= '0;
        end else if (stat_clr_i) begin
            stat_hit_o  <= '0;
            stat_ins_o  <= '0;
            stat_full_o <= '0;
        end else if (rsp_valid_q) begin
            if (rsp_hit_q && stat_hit_o != '1) stat_hit_o <= stat_hit_o + 32'd1;
            if (rsp_full_q && stat_full_o != '1) stat_full_o <= stat_full_o + 32'd1;
            if (!rsp_hit_q && !rsp_full_q && stat_ins_o != '1) stat_ins_o <= stat_ins_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cam_alloc.sv
// Self-checking bench for cam_alloc: behavioural CAM plus a set-based reference model.
module tb_cam_alloc;
    localparam int CNT_N  = 32;
    localparam int KEY_W  = 8;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cam_alloc_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();

    logic              free_i;
    logic [ADDR_W-1:0] free_addr;
    logic              cam_rd;
    logic [KEY_W-1:0]  cam_rd_key;
    logic              cam_match;
    logic [ADDR_W-1:0] cam_addr;
    logic              cam_error;
    logic              cam_alloc;
    logic [CNT_N-1:0]  cam_alloc_pos;
    logic [KEY_W-1:0]  cam_alloc_key;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
`ifdef CAM_ALLOC_STATS_EN
    logic              stat_clr = 1'b0;
    logic [31:0]       stat_hit, stat_ins, stat_full;
`endif

    cam_alloc #(.CNT_N(CNT_N), .KEY_W(KEY_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (bus.slave),
        .free_i          (free_i),
        .free_addr_i     (free_addr),
        .cam_rd_o        (cam_rd),
        .cam_rd_key_o    (cam_rd_key),
        .cam_match_i     (cam_match),
        .cam_addr_i      (cam_addr),
        .cam_error_i     (cam_error),
        .cam_alloc_o     (cam_alloc),
        .cam_alloc_pos_o (cam_alloc_pos),
        .cam_alloc_key_o (cam_alloc_key),
        .count_o         (count),
        .full_o          (full),
        .err_o           (err)
`ifdef CAM_ALLOC_STATS_EN
        ,
        .stat_clr_i      (stat_clr),
        .stat_hit_o      (stat_hit),
        .stat_ins_o      (stat_ins),
        .stat_full_o     (stat_full)
`endif
    );

    // Behavioural CAM: valid bits are never cleared, only overwritten by alloc.
    logic [KEY_W-1:0] cam_key_m [CNT_N] = '{default: '0};
    logic             cam_vld_m [CNT_N] = '{default: 1'b0};
    logic             force_err = 1'b0;

    always_comb begin
        int n;
        n = 0;
        cam_match = 1'b0;
        cam_addr  = '0;
        for (int i = 0; i < CNT_N; i++) begin
            if (cam_vld_m[i] && cam_key_m[i] == cam_rd_key) begin
                if (!cam_match) cam_addr = ADDR_W'(i);
                cam_match = 1'b1;
                n++;
            end
        end
        cam_error = (n > 1) || force_err;
    end

    int               alloc_cnt = 0;
    int               pos_bad = 0;
    logic [CNT_N-1:0] last_pos = '0;

    always @(negedge clk) begin
        if (cam_alloc) begin
            alloc_cnt = alloc_cnt + 1;
            last_pos  = cam_alloc_pos;
            for (int i = 0; i < CNT_N; i++) begin
                if (cam_alloc_pos[i]) begin
                    cam_key_m[i] = cam_alloc_key;
                    cam_vld_m[i] = 1'b1;
                end
            end
        end else if (cam_alloc_pos != '0) begin
            pos_bad = pos_bad + 1;
        end
    end

    // Reference model: set of owned slots, occupancy count, sticky error.
    bit ref_used [CNT_N];
    int ref_count;
    bit ref_err;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < CNT_N; i++) ref_used[i] = 1'b0;
        ref_count = 0;
        ref_err   = 1'b0;
    endtask

    task automatic ref_free(input int fa);
        if (fa < CNT_N && ref_used[fa]) begin
            ref_used[fa] = 1'b0;
            ref_count--;
        end else begin
            ref_err = 1'b1;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(ref_count));
        chk({tag, "_full"},  64'(full),  64'(ref_count == CNT_N));
        chk({tag, "_err"},   64'(err),   64'(ref_err));
    endtask

    task automatic wait_ready(output bit ok);
        int w = 0;
        while (!bus.req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = bus.req_ready_o;
        chk("accept_ready", 64'(ok), 64'd1);
    endtask

    task automatic insert(input logic [KEY_W-1:0] k, input bit do_free, input int fa, input bit ferr);
        int live_at = -1, stale_at = -1, low = -1;
        int exp_addr, lat, a0;
        bit exp_hit, exp_full, exp_ins, ok;

        for (int i = 0; i < CNT_N; i++) begin
            if (cam_vld_m[i] && cam_key_m[i] == k) begin
                if (ref_used[i] && !(do_free && fa == i)) live_at = i;
                else stale_at = i;
            end
        end
        for (int i = CNT_N - 1; i >= 0; i--) if (!ref_used[i]) low = i;
        exp_hit = 0; exp_full = 0; exp_ins = 0; exp_addr = 0;
        if (live_at >= 0) begin
            exp_hit = 1; exp_addr = live_at;
        end else if (stale_at >= 0) begin
            exp_ins = 1; exp_addr = stale_at;
        end else if (ref_count < CNT_N) begin
            exp_ins = 1; exp_addr = low;
        end else begin
            exp_full = 1;
        end

        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_key_i   = k;
        wait_ready(ok);
        if (!ok) begin
            bus.req_valid_i = 1'b0;
            return;
        end
        a0 = alloc_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        force_err = ferr;
        if (do_free) begin
            free_i    = 1'b1;
            free_addr = ADDR_W'(fa);
        end
        lat = 1;
        while (!bus.rsp_valid_o && lat < 8) begin
            @(negedge clk);
            free_i    = 1'b0;
            force_err = 1'b0;
            lat++;
        end
        free_i    = 1'b0;
        force_err = 1'b0;

        if (do_free) ref_free(fa);
        if (exp_ins) begin
            ref_used[exp_addr] = 1'b1;
            ref_count++;
        end
        if (ferr) ref_err = 1'b1;

        chk("rsp_latency", 64'(lat), exp_ins ? 64'd3 : 64'd2);
        chk("rsp_hit",     64'(bus.rsp_hit_o),  64'(exp_hit));
        chk("rsp_full",    64'(bus.rsp_full_o), 64'(exp_full));
        chk("rsp_addr",    64'(bus.rsp_addr_o), 64'(exp_addr));
        chk("alloc_pulses", 64'(alloc_cnt - a0), exp_ins ? 64'd1 : 64'd0);
        if (exp_ins) chk("alloc_pos", 64'(last_pos), 64'd1 << exp_addr);
        chk_state("ins");
    endtask

    task automatic free_op(input int fa);
        @(negedge clk);
        free_i    = 1'b1;
        free_addr = ADDR_W'(fa);
        @(negedge clk);
        free_i = 1'b0;
        ref_free(fa);
        chk_state("free");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_clear();
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int a0;
        reset           = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_key_i   = '0;
        free_i          = 1'b0;
        free_addr       = '0;
        ref_clear();
        repeat (3) @(negedge clk);
        chk("rst_ready",     64'(bus.req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_cam_rd",    64'(cam_rd),          64'd0);
        chk("rst_cam_alloc", 64'(cam_alloc),       64'd0);
        chk("rst_pos",       64'(cam_alloc_pos),   64'd0);
        chk_state("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready_o), 64'd1);

        insert(8'h11, 0, 0, 0);
        insert(8'h22, 0, 0, 0);
        insert(8'h33, 0, 0, 0);
        insert(8'h22, 0, 0, 0);
        free_op(1);
        insert(8'h22, 0, 0, 0);
        for (int i = 3; i < CNT_N; i++) insert(8'(8'h40 + i), 0, 0, 0);
        insert(8'hAA, 0, 0, 0);
        free_op(7);
        insert(8'hAA, 0, 0, 0);
        // Free during LOOKUP of a live key: the hit is masked and the slot reused.
        insert(8'h33, 1, 2, 0);
        insert(8'h11, 0, 0, 1);

        // Reset while the request sits in LOOKUP.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_key_i   = 8'h77;
        wait_ready(ok);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        reset = 1'b1;
        a0 = alloc_cnt;
        ref_clear();
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_rsp", 64'(bus.rsp_valid_o), 64'd0);
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_rsp_after", 64'(bus.rsp_valid_o), 64'd0);
        end
        chk("rst_mid_alloc", 64'(alloc_cnt - a0), 64'd0);
        chk("rst_mid_ready", 64'(bus.req_ready_o), 64'd1);
        chk_state("rst_mid");

        free_op(5);
        free_op(5);
        insert(8'h11, 0, 0, 0);
        do_reset();

        for (int n = 0; n < 200; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) insert(8'($urandom_range(0, 23)), ($urandom_range(0, 4) == 0),
                              int'($urandom_range(0, CNT_N - 1)), 0);
            else free_op(int'($urandom_range(0, CNT_N - 1)));
        end

        chk("pos_outside_alloc", 64'(pos_bad), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cam_alloc.md
Name: cam_alloc

Overview:
- Insert/free controller directly upstream of the CAM table.
- Takes key-insert requests on a valid/ready handshake and issues a CAM read to detect duplicates.
- On a miss, picks a free entry and drives the CAM alloc port with a one-hot position; keeps the authoritative occupancy bitmap.
- The CAM cannot clear entry valid bits, so this block masks stale hits on freed entries.

Parameters:
- CNT_N, 32, number of CAM entries; must match the CAM.
- KEY_W, 8, key width; must match the CAM.
- ADDR_W, $clog2(CNT_N), entry address width (localparam).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  1  insert request valid
- req_ready_o  out  1  block can accept a request
- req_key_i  in  KEY_W  key to insert
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_hit_o  out  1  key already present
- rsp_full_o  out  1  request rejected, table full
- rsp_addr_o  out  ADDR_W  entry holding the key; 0 when rsp_full_o
- free_i  in  1  release an entry
- free_addr_i  in  ADDR_W  entry to release
- cam_rd_o  out  1  to CAM rd_i
- cam_rd_key_o  out  KEY_W  to CAM rd_key_i
- cam_match_i  in  1  from CAM match_o
- cam_addr_i  in  ADDR_W  from CAM addr_o
- cam_error_i  in  1  from CAM error_o (multi-hit)
- cam_alloc_o  out  1  to CAM alloc_i
- cam_alloc_pos_o  out  CNT_N  to CAM alloc_pos_i, one-hot or zero
- cam_alloc_key_o  out  KEY_W  to CAM alloc_key_i
- count_o  out  ADDR_W+1  number of occupied entries
- full_o  out  1  count_o == CNT_N
- err_o  out  1  sticky: CAM multi-hit seen, or bad free

Behaviour:
- Reset (async, active-high):
  - State IDLE; bitmap all-zero; count_o=0; err_o=0.
  - All cam_* outputs 0; rsp_* all 0.
  - req_ready_o=0 while reset is asserted, 1 after release.
  - Reset mid-operation abandons the request: no response, no alloc.
- FSM states: IDLE, LOOKUP, ALLOC, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch key_q and go to LOOKUP.
- LOOKUP (1 cycle):
  - cam_rd_o=1, cam_rd_key_o=key_q.
  - CAM is combinational; sample cam_match_i/cam_addr_i in the same cycle.
  - live_hit = cam_match_i & used[cam_addr_i] & ~(free_i & free_addr_i==cam_addr_i).
  - live_hit: go to RESP with hit=1, addr=cam_addr_i.
  - Stale match (cam_match_i & ~live_hit): go to ALLOC with target=cam_addr_i. Reusing that slot prevents duplicate keys in the CAM.
  - No match & ~full_o: go to ALLOC with target = lowest-index zero bit of used.
  - No match & full_o: go to RESP with full=1, addr=0.
  - cam_error_i=1: set err_o; otherwise proceed as above.
- ALLOC (1 cycle):
  - cam_alloc_o=1, cam_alloc_pos_o=1<<target, cam_alloc_key_o=key_q.
  - Set used[target]; count +1.
  - Go to RESP with hit=0, addr=target.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; no backpressure.
  - Return to IDLE; req_ready_o is low here.
- Latency from accept cycle N:
  - Hit or full: rsp_valid_o at N+2.
  - Insert: rsp_valid_o at N+3.
  - Throughput: one request per 3 or 4 cycles.
- Free (accepted in any state except during reset):
  - If used[free_addr_i]: clear it next edge, count -1.
  - Else: ignore and set err_o.
  - free_addr_i >= CNT_N: ignore and set err_o.
- Same-cycle free and ALLOC, different entry: count unchanged net; both bitmap updates applied.
- Same-cycle free and ALLOC, same entry: impossible, since target is chosen from cleared bits; a free of it is a bad free.
- Free during LOOKUP: target selection uses the pre-free bitmap. The freed slot becomes available for the next request.
- cam_alloc_pos_o is zero outside ALLOC.
- count_o never wraps: 0..CNT_N.

Optional Feature:
- Macro: CAM_ALLOC_STATS_EN.
- Defined: adds outputs stat_hit_o, stat_ins_o, stat_full_o (32 bits each).
  - Each increments on the matching rsp_valid_o and saturates at 2^32-1.
  - All clear on reset and on an added input stat_clr_i (1-cycle pulse).
  - stat_clr_i has priority over a same-cycle increment.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Insert keys 0x11, 0x22, 0x33 from reset -> responses hit=0 with addr 0, 1, 2; each rsp at accept+3; count_o=3; one cam_alloc_pos_o pulse each (0x1, 0x2, 0x4).
- Insert 0x22 again -> rsp at accept+2, hit=1, addr=1; no cam_alloc_o pulse; count_o stays 3.
- Free addr 1, then insert 0x22 -> CAM stale match masked; ALLOC with pos=0x2; rsp hit=0, addr=1; count_o=3.
- Fill all 32 entries, insert new key 0xAA -> rsp_full_o=1, addr=0, no alloc. Then free addr 7 and insert 0xAA -> addr=7.
- Free addr 5 while unused -> err_o=1 and stays 1; count_o unchanged. Force cam_error_i in LOOKUP -> err_o=1.
- Assert reset during LOOKUP -> no rsp_valid_o, no cam_alloc_o; count_o=0; req_ready_o=1 after release.
